// File: rtl/div_sequencer.sv
// div_sequencer
//
// Handshake front-end for the 8-bit restoring divider in the ALU path.
// An operand pair is accepted over a valid/ready input, registered onto the
// divider operand inputs, and the divider is enabled for a fixed settle
// window. Quotient and remainder are then captured and held on a valid/ready
// output until writeback takes them. A zero divisor is caught here: the
// divider is never started and an all-ones quotient with the dividend as
// remainder is returned with out_dbz set.
//
// Parameters
//   WIDTH  : operand/result width, must match the divider
//   SETTLE : cycles div_en stays high before capture (1..15)
//
// Ports
//   clk          : clock, everything on the rising edge
//   rst_n        : synchronous active-low reset
//   in_valid     : operand pair present
//   in_ready     : block can accept an operand pair
//   in_dividend  : dividend
//   in_divisor   : divisor
//   div_dividend : registered dividend to the divider
//   div_divisor  : registered divisor to the divider
//   div_en       : divider start, rising edge triggers a division
//   div_quo      : divider quotient
//   div_rem      : divider remainder
//   out_valid    : result valid
//   out_ready    : downstream accepts the result
//   out_quo      : captured quotient
//   out_rem      : captured remainder
//   out_dbz      : divide-by-zero flag, qualified by out_valid
//   busy         : high whenever the sequencer is not idle

module div_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_en,
    input  logic [WIDTH-1:0] div_quo,
    input  logic [WIDTH-1:0] div_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter starts at SETTLE-1 and RUN ends on the cycle it reads zero,
    // which keeps div_en high for exactly SETTLE cycles.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       armed;
    logic       accept;
    logic       divisor_zero;
    logic       capture;

    // armed holds in_ready low for the reset edge itself, so the block only
    // advertises readiness from the first edge that sees rst_n high.
    assign accept       = in_valid && in_ready;
    assign divisor_zero = (in_divisor == '0);
    assign capture      = (state == RUN) && (cnt == 4'd0);
    assign busy         = (state != IDLE);

    // Next-state and handshake outputs. DONE never looks at in_valid, so a
    // result being taken and a new operand arriving in the same cycle only
    // retire the result; the operand is accepted from IDLE afterwards.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        div_en    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (in_valid && armed) begin
                    if (divisor_zero) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            RUN: begin
                div_en = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, operand and result registers. Operand registers only load on a
    // real division so they stay put across a divide-by-zero, and results
    // only change on a capture so they persist after the output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            armed        <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            out_quo      <= '0;
            out_rem      <= '0;
            out_dbz      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            armed <= 1'b1;
            if (accept) begin
                if (divisor_zero) begin
                    out_quo <= '1;
                    out_rem <= in_dividend;
                    out_dbz <= 1'b1;
                end else begin
                    div_dividend <= in_dividend;
                    div_divisor  <= in_divisor;
                end
            end
            if (capture) begin
                out_quo <= div_quo;
                out_rem <= div_rem;
                out_dbz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
//
// Self-checking bench for div_sequencer. A default build (SETTLE=2) carries
// the directed scenarios and a randomized run; a second SETTLE=1 build checks
// the short settle window. Expected results come from plain integer division
// of the operands sent, and expected timing from the settle window length.

module tb_div_sequencer;

    localparam int S  = 2;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [7:0] in_divisor;
    logic [7:0] div_dividend;
    logic [7:0] div_divisor;
    logic       div_en;
    logic [7:0] div_quo;
    logic [7:0] div_rem;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quo;
    logic [7:0] out_rem;
    logic       out_dbz;
    logic       busy;

    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_in_dividend;
    logic [7:0] b_in_divisor;
    logic [7:0] b_div_dividend;
    logic [7:0] b_div_divisor;
    logic       b_div_en;
    logic [7:0] b_div_quo;
    logic [7:0] b_div_rem;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [7:0] b_out_quo;
    logic [7:0] b_out_rem;
    logic       b_out_dbz;
    logic       b_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stand-in for the divider: correct results only while enabled, a junk
    // pattern otherwise, so a capture outside the enable window shows up.
    assign div_quo   = div_en ? ((div_divisor != 8'd0) ? div_dividend / div_divisor : 8'hFF) : 8'hA5;
    assign div_rem   = div_en ? ((div_divisor != 8'd0) ? div_dividend % div_divisor : 8'h00) : 8'h5A;
    assign b_div_quo = b_div_en ? ((b_div_divisor != 8'd0) ? b_div_dividend / b_div_divisor : 8'hFF) : 8'hA5;
    assign b_div_rem = b_div_en ? ((b_div_divisor != 8'd0) ? b_div_dividend % b_div_divisor : 8'h00) : 8'h5A;

    div_sequencer #(.WIDTH(8), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_en(div_en), .div_quo(div_quo), .div_rem(div_rem),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quo(out_quo), .out_rem(out_rem), .out_dbz(out_dbz),
        .busy(busy)
    );

    div_sequencer #(.WIDTH(8), .SETTLE(S1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_dividend(b_in_dividend), .in_divisor(b_in_divisor),
        .div_dividend(b_div_dividend), .div_divisor(b_div_divisor),
        .div_en(b_div_en), .div_quo(b_div_quo), .div_rem(b_div_rem),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_quo(b_out_quo), .out_rem(b_out_rem), .out_dbz(b_out_dbz),
        .busy(b_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One transaction on the SETTLE=2 build. Called at a negedge. Latency is
    // counted in edges from the edge that opens the accept cycle. With chain
    // set, the next operand pair is presented with in_valid high for the
    // whole operation, including the cycle the result is taken.
    task automatic applyStimulus(input logic [7:0] dvd, input logic [7:0] dvs, input int hold,
                                 input bit chain, input logic [7:0] nDvd, input logic [7:0] nDvs);
        logic [7:0] expQuo;
        logic [7:0] expRem;
        logic       expDbz;
        logic [7:0] prevDvd;
        logic [7:0] prevDvs;
        int         expLat;
        int         expEn;
        int         guard;
        int         lat;
        int         enCycles;
        bit         readyBad;
        bit         opsBad;
        bit         holdBad;
        if (dvs == 8'd0) begin
            expQuo = 8'hFF; expRem = dvd; expDbz = 1'b1; expLat = 1; expEn = 0;
        end else begin
            expQuo = dvd / dvs; expRem = dvd % dvs; expDbz = 1'b0; expLat = S + 1; expEn = S;
        end
        in_dividend = dvd;
        in_divisor  = dvs;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptWait", 32'(guard < 50), 32'd1);
        prevDvd = div_dividend;
        prevDvs = div_divisor;
        @(negedge clk);
        if (chain) begin
            in_dividend = nDvd;
            in_divisor  = nDvs;
        end else begin
            in_valid    = 1'b0;
            in_dividend = 8'($urandom);
            in_divisor  = 8'($urandom);
        end
        lat = 1; enCycles = 0; readyBad = 1'b0; opsBad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (div_en) begin
                enCycles++;
                if (div_dividend !== dvd || div_divisor !== dvs) opsBad = 1'b1;
            end
            if (in_ready) readyBad = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("divEnCycles", 32'(enCycles), 32'(expEn));
        checkOutput("opsStable", 32'(opsBad), 32'd0);
        checkOutput("opsRegs", {16'd0, div_dividend, div_divisor},
                    (dvs == 8'd0) ? {16'd0, prevDvd, prevDvs} : {16'd0, dvd, dvs});
        checkOutput("quo", 32'(out_quo), 32'(expQuo));
        checkOutput("rem", 32'(out_rem), 32'(expRem));
        checkOutput("dbz", 32'(out_dbz), 32'(expDbz));
        holdBad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || out_quo !== expQuo || out_rem !== expRem || out_dbz !== expDbz || div_en)
                holdBad = 1'b1;
            if (in_ready) readyBad = 1'b1;
        end
        checkOutput("holdStable", 32'(holdBad), 32'd0);
        if (in_ready) readyBad = 1'b1;
        checkOutput("inReadyLow", 32'(readyBad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("idleAfterTake", {30'd0, busy, out_valid}, 32'd0);
        checkOutput("keptResult", {15'd0, out_quo, out_rem, out_dbz}, {15'd0, expQuo, expRem, expDbz});
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd [0:40];
        logic [7:0] rs [0:40];
        int         lat;
        int         enCycles;
        bit         sawValid;
        bit         ch;

        rst_n = 1'b0;
        in_valid = 1'b0; in_dividend = 8'd0; in_divisor = 8'd0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_dividend = 8'd0; b_in_divisor = 8'd0; b_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstCtrl", {27'd0, in_ready, div_en, out_valid, out_dbz, busy}, 32'd0);
        checkOutput("rstData", {div_dividend, div_divisor, out_quo, out_rem}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRst", 32'(in_ready), 32'd1);

        // Basic division, back-to-back pair, divide-by-zero, backpressure
        applyStimulus(8'd100, 8'd7, 0, 1'b0, 8'd0, 8'd0);
        applyStimulus(8'd255, 8'd16, 0, 1'b1, 8'd0, 8'd5);
        applyStimulus(8'd0, 8'd5, 0, 1'b0, 8'd0, 8'd0);
        applyStimulus(8'd37, 8'd0, 0, 1'b0, 8'd0, 8'd0);
        applyStimulus(8'd200, 8'd3, 5, 1'b0, 8'd0, 8'd0);

        // Reset in the middle of RUN
        in_dividend = 8'd50; in_divisor = 8'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midRunEn", {30'd0, busy, div_en}, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstCtrl", {27'd0, in_ready, div_en, out_valid, out_dbz, busy}, 32'd0);
        checkOutput("midRstData", {div_dividend, div_divisor, out_quo, out_rem}, 32'd0);
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || div_en) sawValid = 1'b1;
        end
        checkOutput("noResultAfterRst", 32'(sawValid), 32'd0);
        applyStimulus(8'd9, 8'd4, 0, 1'b0, 8'd0, 8'd0);

        // Randomized operations with random backpressure and chaining
        for (int i = 0; i < 41; i++) begin
            rd[i] = 8'($urandom);
            rs[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
        end
        for (int i = 0; i < 40; i++) begin
            ch = (i < 39) && ($urandom_range(0, 1) == 1);
            applyStimulus(rd[i], rs[i], int'($urandom_range(0, 3)), ch, rd[i+1], rs[i+1]);
        end

        // SETTLE=1 build: 81/9
        b_in_dividend = 8'd81; b_in_divisor = 8'd9; b_in_valid = 1'b1;
        lat = 0;
        while (!b_in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("s1AcceptWait", 32'(lat < 50), 32'd1);
        b_out_ready = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 1; enCycles = 0;
        while (!b_out_valid && lat < 40) begin
            if (b_div_en) enCycles++;
            @(negedge clk);
            lat++;
        end
        checkOutput("s1Latency", 32'(lat), 32'(S1 + 1));
        checkOutput("s1DivEnCycles", 32'(enCycles), 32'(S1));
        checkOutput("s1Result", {15'd0, b_out_quo, b_out_rem, b_out_dbz}, {15'd0, 8'd9, 8'd0, 1'b0});
        b_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("s1Idle", 32'(b_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
